// File: rtl/hex_disp_ctrl_pkg.sv
// Shared types, segment constants and the nibble-to-segment table for the
// hex display controller.
package hex_disp_pkg;

  // Active-low segments, bit order g,f,e,d,c,b,a (bit 0 = a/top, bit 6 = g/middle).
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK  = 7'h7F;
  localparam seg_t SEG_ALL_ON = 7'h00;

  function automatic seg_t hex2seg(input logic [3:0] hex);
    seg_t seg;
    case (hex)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_digit_dec.sv
// Combinational decoder for one hex digit; the blank input overrides the
// nibble and turns every segment off.
module hex_digit_dec
  import hex_disp_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output seg_t       seg
);

  // Blank wins over the decoded glyph.
  always_comb begin
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      seg = hex2seg(nibble);
    end
  end

endmodule

// File: rtl/hex_disp_ctrl.sv
// N-digit registered hex display controller: value capture, leading-zero
// blanking, prescaled per-digit blinking and lamp test.
module hex_disp_ctrl
  import hex_disp_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     blink_en,
  input  logic                  blank_lz,
  input  logic                  lamp_test,
  output logic [7*DIGITS-1:0]   segs,
  output logic [4*DIGITS-1:0]   shown,
  output logic                  blink_phase
);

  localparam int            CW      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

  logic [4*DIGITS-1:0] shown_r;
  logic [DIGITS-1:0]   mask_r;
  logic [CW-1:0]       cnt_r;
  logic                phase_r;
  logic [7*DIGITS-1:0] segs_r;

  logic [DIGITS-1:0]   lz_blank_s;
  logic                upper_zero_s;
  logic [DIGITS-1:0]   dig_blank_s;
  logic [7*DIGITS-1:0] dec_segs_s;
  logic [7*DIGITS-1:0] segs_next_s;

  // Capture register for the displayed value and its blink mask.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shown_r <= {(4*DIGITS){1'b0}};
      mask_r  <= {DIGITS{1'b0}};
    end else if (load) begin
      shown_r <= value;
      mask_r  <= blink_en;
    end else begin
      shown_r <= shown_r;
      mask_r  <= mask_r;
    end
  end

  // Free-running blink prescaler; the phase flips each time the count wraps.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r   <= {CW{1'b0}};
      phase_r <= 1'b0;
    end else if (cnt_r == CNT_MAX) begin
      cnt_r   <= {CW{1'b0}};
      phase_r <= ~phase_r;
    end else begin
      cnt_r   <= cnt_r + CW'(1);
      phase_r <= phase_r;
    end
  end

  // Leading-zero chain walks down from the top digit; digit 0 always shows.
  always_comb begin
    lz_blank_s   = {DIGITS{1'b0}};
    upper_zero_s = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero_s  = upper_zero_s & (shown_r[4*i +: 4] == 4'h0);
      lz_blank_s[i] = blank_lz & upper_zero_s;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign dig_blank_s[g] = (phase_r & mask_r[g]) | lz_blank_s[g];

    hex_digit_dec u_dec (
      .nibble (shown_r[4*g +: 4]),
      .blank  (dig_blank_s[g]),
      .seg    (dec_segs_s[7*g +: 7])
    );
  end

  // Lamp test overrides every digit, including blanked ones.
  always_comb begin
    if (lamp_test) begin
      segs_next_s = {DIGITS{SEG_ALL_ON}};
    end else begin
      segs_next_s = dec_segs_s;
    end
  end

  // Output register driving the pins; dark while in reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      segs_r <= {DIGITS{SEG_BLANK}};
    end else begin
      segs_r <= segs_next_s;
    end
  end

  assign segs        = segs_r;
  assign shown       = shown_r;
  assign blink_phase = phase_r;

endmodule

// File: tb/tb_hex_disp_ctrl.sv
// Self-checking bench for hex_disp_ctrl: behavioural model compared every
// cycle, directed literal checks, and a randomized phase.
module tb_hex_disp_ctrl;

  localparam int DIGITS    = 4;
  localparam int BLINK_DIV = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic [3:0]  blink_en;
  logic        blank_lz;
  logic        lamp_test;
  logic [27:0] segs;
  logic [15:0] shown;
  logic        blink_phase;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hex_disp_ctrl #(.DIGITS(DIGITS), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .reset(reset), .load(load), .value(value), .blink_en(blink_en),
    .blank_lz(blank_lz), .lamp_test(lamp_test), .segs(segs), .shown(shown),
    .blink_phase(blink_phase)
  );

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [27:0] model_segs(input logic [15:0] v, input logic [3:0] m,
                                             input logic ph, input logic blz, input logic lamp);
    logic [27:0] r;
    for (int i = 0; i < DIGITS; i++) begin
      if (lamp)                                  r[7*i +: 7] = 7'h00;
      else if (ph && m[i])                       r[7*i +: 7] = 7'h7F;
      else if (blz && i > 0 && (v >> (4*i)) == 0) r[7*i +: 7] = 7'h7F;
      else                                       r[7*i +: 7] = seg_tab[v[4*i +: 4]];
    end
    return r;
  endfunction

  // Reference model state
  logic [15:0] m_shown;
  logic [3:0]  m_mask;
  int          m_cnt;
  logic        m_phase;
  logic        m_valid = 1'b0;
  logic [27:0] m_segs;

  always begin
    @(posedge clk);
    if (!reset) begin
      m_segs  = {28{1'b1}};
      m_shown = 16'h0;
      m_mask  = 4'h0;
      m_cnt   = 0;
      m_phase = 1'b0;
      m_valid = 1'b1;
    end else begin
      m_segs = model_segs(m_shown, m_mask, m_phase, blank_lz, lamp_test);
      if (load) begin
        m_shown = value;
        m_mask  = blink_en;
      end
      m_cnt = (m_cnt + 1) % BLINK_DIV;
      if (m_cnt == 0) m_phase = ~m_phase;
    end
    #1;
    if (m_valid) begin
      check("model_segs", segs, m_segs);
      check("model_shown", shown, m_shown);
      check("model_phase", blink_phase, m_phase);
    end
  end

  task automatic wait_phase_rise(input string name);
    bit found = 0;
    bit prev  = blink_phase;
    for (int i = 0; i < 24 && !found; i++) begin
      @(negedge clk);
      if (!prev && blink_phase) found = 1;
      prev = blink_phase;
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL %s: blink_phase never rose within 24 cycles", name);
    end
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; value = 16'h0; blink_en = 4'h0;
    blank_lz = 1'b0; lamp_test = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_segs", segs, {28{1'b1}});
    check("reset_shown", shown, 16'h0);
    reset = 1'b1;

    // basic load
    load = 1'b1; value = 16'h1A3F;
    @(negedge clk);
    load = 1'b0;
    check("load_shown", shown, 16'h1A3F);
    @(negedge clk);
    check("load_segs", segs, {7'b1111001, 7'b0001000, 7'b0110000, 7'b0001110});

    // leading-zero blanking
    blank_lz = 1'b1; load = 1'b1; value = 16'h0040;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    check("lz_0040", segs, {7'h7F, 7'h7F, 7'b0011001, 7'b1000000});
    load = 1'b1; value = 16'h0000;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    check("lz_0000", segs, {7'h7F, 7'h7F, 7'h7F, 7'b1000000});
    blank_lz = 1'b0;
    @(negedge clk);
    check("lz_off", segs, {4{7'b1000000}});

    // blink and lamp test
    load = 1'b1; value = 16'h1234; blink_en = 4'b0001;
    @(negedge clk);
    load = 1'b0;
    wait_phase_rise("blink_wait");
    check("blink_lit", segs, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});
    @(negedge clk);
    check("blink_dark", segs, {7'b1111001, 7'b0100100, 7'b0110000, 7'h7F});
    lamp_test = 1'b1;
    @(negedge clk);
    check("lamp_on", segs, 28'h0);
    lamp_test = 1'b0;
    @(negedge clk);
    check("lamp_off", segs, {7'b1111001, 7'b0100100, 7'b0110000, 7'h7F});

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      logic [31:0] r;
      r = $urandom;
      reset     = ($urandom_range(0, 49) != 0);
      load      = ($urandom_range(0, 3) == 0);
      value     = r[15:0] >> (4 * $urandom_range(0, 4));
      blink_en  = 4'($urandom);
      blank_lz  = ($urandom_range(0, 1) == 1);
      lamp_test = ($urandom_range(0, 7) == 0);
      @(negedge clk);
    end
    reset = 1'b1; load = 1'b0; blink_en = 4'h0; blank_lz = 1'b0; lamp_test = 1'b0;

    // load held over three edges: last value wins
    load = 1'b1; value = 16'h1111;
    @(negedge clk);
    value = 16'h2222;
    @(negedge clk);
    value = 16'h3333;
    @(negedge clk);
    load = 1'b0;
    check("hold_shown", shown, 16'h3333);

    // reset during the dark phase, then prescaler restart
    wait_phase_rise("reset_wait");
    reset = 1'b0;
    @(negedge clk);
    check("midreset_segs", segs, {28{1'b1}});
    check("midreset_shown", shown, 16'h0);
    check("midreset_phase", blink_phase, 1'b0);
    reset = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("restart_phase", blink_phase, (k == 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hex_disp_ctrl.md
Name: hex_disp_ctrl

Overview:
- Parametrised N-digit hexadecimal display controller for the DE1-SoC HEX outputs.
- Latches a WIDTH=4*DIGITS value on a load strobe and decodes each nibble to active-low 7-segment codes.
- Adds leading-zero blanking, per-digit blinking from an internal prescaler, and a lamp test.
- Sits between the CPU/datapath output register and the HEX pins; replaces per-digit combinational decoders with one registered block.

Parameters:
- DIGITS, 4, number of hex digits driven (1..8).
- BLINK_DIV, 25000000, clk cycles per blink half-period (>=2); set to 4 in simulation.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (0 = reset).
- load  input  1  when 1 at a clk edge, capture value and blink_en.
- value  input  4*DIGITS  hex value; digit i = value[4i+3:4i], digit 0 least significant.
- blink_en  input  DIGITS  per-digit blink enable, captured with load.
- blank_lz  input  1  live (not captured) leading-zero blanking enable.
- lamp_test  input  1  live; forces all segments on.
- segs  output  7*DIGITS  registered active-low segments; digit i = segs[7i+6:7i], bit order g,f,e,d,c,b,a (bit 0 = top, 6 = middle).
- shown  output  4*DIGITS  currently latched value.
- blink_phase  output  1  current blink phase (1 = blinking digits dark).

Behaviour:
- Reset (reset=0 at edge): shown=0, blink mask=0, prescaler=0, blink_phase=0, segs=all 1 (all dark). Reset overrides load and lamp_test.
- Capture stage: load=1 at edge t gives shown=value and mask=blink_en after edge t.
  - load held several cycles: each edge recaptures; last value wins.
  - load=0: hold.
- Output stage: segs registered from shown/mask/phase/blank_lz/lamp_test. A load at edge t is visible on segs after edge t+1 (2-cycle latency). blank_lz and lamp_test have 1-cycle latency.
- Decode, active-low codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - blank=1111111.
- Leading-zero blanking (blank_lz=1): starting at digit DIGITS-1 and moving down, zero digits are blank until the first nonzero digit. Digit 0 is never blanked by this rule, so value 0 shows a single "0".
- Prescaler: counts 0..BLINK_DIV-1 every cycle. On wrap to 0, blink_phase toggles. Runs independently of load.
- Blink: when blink_phase=1 and mask[i]=1, digit i is blank; otherwise normal.
- Priority per digit: lamp_test (0000000) > blink blank > leading-zero blank > decode.
- Reset mid-operation: all state cleared on that edge; segs dark for one cycle, then show "0" digits per blank_lz.
- Prescaler width is $clog2(BLINK_DIV). No overflow beyond BLINK_DIV-1.

Decomposition:
- Package hex_disp_pkg:
  - typedef seg_t (logic [6:0]).
  - localparams SEG_BLANK=7'h7F and SEG_ALL_ON=7'h00.
  - constant function hex2seg(logic [3:0]) returning the table above.
- Sub-module hex_digit_dec: combinational 4-bit to seg_t with a blank input, instantiated DIGITS times via generate.
- Top-level hex_disp_ctrl holds the capture registers, prescaler, leading-zero chain and output register.

Test Plan:
- 1. Basic load (DIGITS=4, BLINK_DIV=4): reset low 2 cycles, release, load value=16'h1A3F for 1 cycle.
  - Two edges later: digit3=1111001, digit2=0001000, digit1=0110000, digit0=0001110.
  - shown=16'h1A3F one edge after load.
- 2. Leading-zero blanking: blank_lz=1.
  - Load 16'h0040: digits 3,2=1111111, digit1=0011001, digit0=1000000.
  - Load 16'h0000: only digit0=1000000.
  - Set blank_lz=0: all four show 1000000 after 1 edge.
- 3. Blink: load 16'h1234 with blink_en=4'b0001.
  - blink_phase toggles every 4 cycles.
  - digit0 alternates 0011001/1111111 in step with the phase (1-cycle lag); digits 3..1 stay steady.
- 4. Lamp test: lamp_test=1 during the blink dark phase gives segs=0 on all digits next edge. Drop it and the prior display resumes next edge.
- 5. Load hold and reset: hold load 3 cycles with value 16'h1111, 16'h2222, 16'h3333 → shown=16'h3333.
  - Assert reset while blink_phase=1: next edge segs=all 1, shown=0, blink_phase=0, prescaler restarts from 0.
